nonce_result_queue: RTL and testbench

- Collects golden-nonce pulses from all miner slaves, both local hashcores and external-port receivers, in the uart clock domain.
- Buffers results in a FIFO so that simultaneous or back-to-back finds are not lost.
- Drives the send/busy handshake of the serial transmitter.
- Sits between the per-slave nonce sources and serial_transmit, replacing the unbuffered hub arbiter.

---
 rtl/nonce_result_queue_pkg.sv | 20 ++
 rtl/nonce_fifo.sv | 54 +++++
 rtl/nonce_result_queue.sv | 121 ++++++++++++
 tb/tb_nonce_result_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_result_queue_pkg.sv
// Shared types and constants for the nonce result queue: word width, transmit
// FSM encoding and a constant-evaluable ceiling log2.
package nonce_result_queue_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_IDLE = 2'd2
    } tx_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is valid whenever empty=0.
// Push is ignored when full unless a pop happens in the same cycle.
module nonce_fifo
    import nonce_result_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_dat,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_dat,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/nonce_result_queue.sv
// Captures per-slave nonce pulses, round-robin arbitrates them into a FWFT FIFO and
// feeds the serial transmitter; pulse to serial_send is 2 cycles minimum, sends wait on busy.
module nonce_result_queue
    import nonce_result_queue_pkg::*;
#(
    parameter int SLAVES = 3,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [SLAVES-1:0]           new_nonces,
    input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
    input  logic                        serial_busy,
    output logic                        serial_send,
    output logic [NONCE_W-1:0]          golden_nonce,
    output logic [clog2(DEPTH):0]       fifo_level,
    output logic [DROP_W-1:0]           dropped
);

    localparam int IDX_W = (SLAVES > 1) ? clog2(SLAVES) : 1;

    logic [SLAVES-1:0]  pending;
    logic [NONCE_W-1:0] hold [SLAVES];
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [DROP_W:0]    drop_cnt;
    logic [DROP_W:0]    drop_sum;
    logic [NONCE_W-1:0] fifo_dat;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    tx_state_t          state;

    // Search starts at rr_ptr so the slave after the last winner has first claim.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < SLAVES; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % SLAVES);
            if (!gnt_vld && !fifo_full && pending[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // A pulse on a pending slave that is not being drained loses the older value.
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i] && pending[i] && !(gnt_vld && gnt_idx == IDX_W'(i)))
                drop_cnt = drop_cnt + (DROP_W+1)'(1);
        end
        drop_sum = {1'b0, dropped} + drop_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            rr_ptr  <= '0;
            dropped <= '0;
            for (int i = 0; i < SLAVES; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    hold[i]    <= slave_nonces[i*NONCE_W +: NONCE_W];
                    pending[i] <= 1'b1;
                end else if (gnt_vld && gnt_idx == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (gnt_vld)
                rr_ptr <= (gnt_idx == IDX_W'(SLAVES-1)) ? '0 : gnt_idx + IDX_W'(1);
            dropped <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (gnt_vld),
        .push_dat (hold[gnt_idx]),
        .pop      (pop),
        .head_dat (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign pop = (state == ST_IDLE) && !fifo_empty && !serial_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            serial_send  <= 1'b0;
            golden_nonce <= '0;
        end else begin
            serial_send <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        golden_nonce <= fifo_dat;
                        serial_send  <= 1'b1;
                        state        <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: if (serial_busy)  state <= ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (!serial_busy) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_result_queue.sv
// Directed bench for nonce_result_queue: a 16-deep instance for most scenarios and a
// 4-deep instance for overflow; each has a simple transmitter busy model.
module tb_nonce_result_queue;

    logic        clk;
    logic        reset_n;
    logic [2:0]  new_nonces;
    logic [95:0] slave_nonces;
    logic        serial_busy;
    logic        serial_send;
    logic [31:0] golden_nonce;
    logic [4:0]  fifo_level;
    logic [15:0] dropped;

    logic [2:0]  nn4;
    logic [95:0] sn4;
    logic        busy4;
    logic        send4;
    logic [31:0] gold4;
    logic [2:0]  lvl4;
    logic [15:0] drop4;

    logic        hold_busy, model_busy, hold4, model4;
    int          busy_cnt, busy4_cnt;
    logic        send_d, prev_send, send4_d;
    logic [31:0] sends[$];
    logic [31:0] sends4[$];
    int          n_total, n_pass;

    assign serial_busy = hold_busy | model_busy;
    assign busy4       = hold4 | model4;

    nonce_result_queue #(.SLAVES(3), .DEPTH(16), .DROP_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .new_nonces(new_nonces), .slave_nonces(slave_nonces),
        .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
        .fifo_level(fifo_level), .dropped(dropped)
    );

    nonce_result_queue #(.SLAVES(3), .DEPTH(4), .DROP_W(16)) dut4 (
        .clk(clk), .reset_n(reset_n), .new_nonces(nn4), .slave_nonces(sn4),
        .serial_busy(busy4), .serial_send(send4), .golden_nonce(gold4),
        .fifo_level(lvl4), .dropped(drop4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endfunction

    // Transmitter model: busy rises the cycle after a send and stays high 10 cycles.
    always @(negedge clk) begin
        if (serial_send) begin
            check("send_one_cycle", {31'd0, prev_send}, 32'd0);
            check("send_after_busy_low", {31'd0, serial_busy}, 32'd0);
            sends.push_back(golden_nonce);
        end
        prev_send = serial_send;
        if (busy_cnt != 0) busy_cnt--;
        if (send_d) busy_cnt = 10;
        send_d     = serial_send;
        model_busy = (busy_cnt != 0);
    end

    always @(negedge clk) begin
        if (send4) sends4.push_back(gold4);
        if (busy4_cnt != 0) busy4_cnt--;
        if (send4_d) busy4_cnt = 3;
        send4_d = send4;
        model4  = (busy4_cnt != 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        new_nonces = '0;
        nn4        = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_sends(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (sends.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(name, {31'd0, sends.size() >= n}, 32'd1);
    endtask

    typedef struct {
        int          slave;
        logic [31:0] nonce;
        int          lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, base, n;
        n_total = 0; n_pass = 0;
        hold_busy = 1'b0; model_busy = 1'b0; busy_cnt = 0; send_d = 1'b0; prev_send = 1'b0;
        hold4 = 1'b0; model4 = 1'b0; busy4_cnt = 0; send4_d = 1'b0;
        reset_n = 1'b0; new_nonces = '0; slave_nonces = '0; nn4 = '0; sn4 = '0;

        vecs[0] = '{1, 32'hDEADBEEF, 3};
        vecs[1] = '{0, 32'h00000000, 3};
        vecs[2] = '{1, 32'h12345678, 3};
        vecs[3] = '{2, 32'hFFFFFFFF, 3};

        do_reset();
        check("rst_send",    {31'd0, serial_send}, 32'd0);
        check("rst_golden",  golden_nonce, 32'd0);
        check("rst_level",   {27'd0, fifo_level}, 32'd0);
        check("rst_dropped", {16'd0, dropped}, 32'd0);

        // Single results: latency counted in ticks after the driving tick.
        for (int v = 0; v < 4; v++) begin
            new_nonces = 3'b001 << vecs[v].slave;
            slave_nonces[vecs[v].slave*32 +: 32] = vecs[v].nonce;
            tick();
            new_nonces = '0;
            lat = 1;
            while (!serial_send && lat < 20) begin
                tick();
                lat++;
            end
            check("single_latency", lat, vecs[v].lat);
            check("single_golden",  golden_nonce, vecs[v].nonce);
            check("single_level",   {27'd0, fifo_level}, 32'd0);
            for (int t = 0; t < 20; t++) tick();
            check("single_dropped", {16'd0, dropped}, 32'd0);
        end

        // Simultaneous pulses from three slaves.
        do_reset();
        base = sends.size();
        new_nonces   = 3'b111;
        slave_nonces = {32'h33333333, 32'h22222222, 32'h11111111};
        tick();
        new_nonces = '0;
        wait_sends(base + 3, 200, "simul_count");
        if (sends.size() >= base + 3) begin
            check("simul_0", sends[base],     32'h11111111);
            check("simul_1", sends[base + 1], 32'h22222222);
            check("simul_2", sends[base + 2], 32'h33333333);
        end
        check("simul_dropped", {16'd0, dropped}, 32'd0);

        // Overflow on the 4-deep instance with the transmitter held busy.
        hold4 = 1'b1;
        do_reset();
        for (int v = 1; v <= 7; v++) begin
            nn4 = 3'b001;
            sn4[31:0] = 32'(v);
            tick();
            nn4 = '0;
            tick();
        end
        tick();
        check("ovf_level",   {29'd0, lvl4}, 32'd4);
        check("ovf_dropped", {16'd0, drop4}, 32'd2);
        hold4 = 1'b0;
        n = 0;
        while (sends4.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        check("ovf_count", sends4.size(), 32'd5);
        if (sends4.size() >= 5) begin
            check("ovf_0", sends4[0], 32'd1);
            check("ovf_1", sends4[1], 32'd2);
            check("ovf_2", sends4[2], 32'd3);
            check("ovf_3", sends4[3], 32'd4);
            check("ovf_4", sends4[4], 32'd7);
        end
        check("ovf_dropped_end", {16'd0, drop4}, 32'd2);

        // Slave 2 pulses again in the cycle it is granted.
        do_reset();
        base = sends.size();
        new_nonces = 3'b100;
        slave_nonces[64 +: 32] = 32'hAAAA0000;
        tick();
        slave_nonces[64 +: 32] = 32'hBBBB0000;
        tick();
        new_nonces = '0;
        wait_sends(base + 2, 100, "regrant_count");
        if (sends.size() >= base + 2) begin
            check("regrant_0", sends[base],     32'hAAAA0000);
            check("regrant_1", sends[base + 1], 32'hBBBB0000);
        end
        check("regrant_dropped", {16'd0, dropped}, 32'd0);

        // Reset while waiting for busy to fall with two entries still queued.
        do_reset();
        base = sends.size();
        new_nonces   = 3'b111;
        slave_nonces = {32'hC0000003, 32'hC0000002, 32'hC0000001};
        tick();
        new_nonces = '0;
        wait_sends(base + 1, 20, "midrst_first_send");
        for (int t = 0; t < 4; t++) tick();
        check("midrst_level_before", {27'd0, fifo_level}, 32'd2);
        reset_n = 1'b0;
        #1;
        check("midrst_send",   {31'd0, serial_send}, 32'd0);
        check("midrst_golden", golden_nonce, 32'd0);
        check("midrst_level",  {27'd0, fifo_level}, 32'd0);
        tick();
        reset_n = 1'b1;
        n = sends.size();
        for (int t = 0; t < 100; t++) tick();
        check("midrst_no_resend", sends.size(), n);

        // Round-robin between two slaves pulsing every cycle with the transmitter held busy.
        hold_busy = 1'b1;
        do_reset();
        base = sends.size();
        for (int c = 0; c < 20; c++) begin
            new_nonces = 3'b011;
            slave_nonces[0 +: 32]  = 32'h00010000 | 32'(c);
            slave_nonces[32 +: 32] = 32'h00020000 | 32'(c);
            tick();
        end
        new_nonces = '0;
        tick();
        tick();
        check("rr_level_full", {27'd0, fifo_level}, 32'd16);
        hold_busy = 1'b0;
        wait_sends(base + 18, 400, "rr_count");
        if (sends.size() >= base + 18) begin
            for (int k = 0; k < 16; k++)
                check("rr_entry", sends[base + k], ((32'(k % 2) + 32'd1) << 16) | 32'(k));
            check("rr_tail_0", sends[base + 16], 32'h00010013);
            check("rr_tail_1", sends[base + 17], 32'h00020013);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
